avm_arbiter2: RTL and testbench

Two-master Avalon-MM arbiter that shares the single SDRAM/memory Avalon slave port between the CPU memory controller master (m0) and a secondary bus master (m1, e.g. video or floppy/IDE DMA engine). It grants whole transactions, covering both read bursts and multi-beat write bursts. It holds the grant until every beat of a granted burst has completed, and routes read data back to the owning master only. It sits between the CPU memory controller output and the top-level memory slave, and is combinationally transparent when idle.

---
 rtl/avm_arbiter2.sv | 131 +++++++++++++
 tb/tb_avm_arbiter2.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/avm_arbiter2.sv
// Two-master Avalon-MM arbiter: grants whole read/write bursts to m0 or m1,
// locks the grant until the last beat completes and steers read data to the owner.
module avm_arbiter2 #(
    parameter bit RR = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] m0_address,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    input  logic [3:0]  m0_burstcount,
    input  logic        m0_read,
    input  logic        m0_write,
    output logic        m0_waitrequest,
    output logic        m0_readdatavalid,
    output logic [31:0] m0_readdata,
    input  logic [29:0] m1_address,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    input  logic [3:0]  m1_burstcount,
    input  logic        m1_read,
    input  logic        m1_write,
    output logic        m1_waitrequest,
    output logic        m1_readdatavalid,
    output logic [31:0] m1_readdata,
    output logic [29:0] s_address,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    output logic [3:0]  s_burstcount,
    output logic        s_read,
    output logic        s_write,
    input  logic        s_waitrequest,
    input  logic        s_readdatavalid,
    input  logic [31:0] s_readdata
);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t     state_q, state_d;
    logic [3:0] beats_q, beats_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;

    logic       req0, req1, gnt, sel, fwd;

    always_comb begin
        req0 = m0_read | m0_write;
        req1 = m1_read | m1_write;
        // On contention, round-robin favours whoever was not served last.
        if (req0 && req1) gnt = RR ? ~last_q : 1'b0;
        else              gnt = req1;
        sel = (state_q == IDLE) ? gnt : owner_q;
    end

    always_comb begin
        s_address    = sel ? m1_address    : m0_address;
        s_writedata  = sel ? m1_writedata  : m0_writedata;
        s_byteenable = sel ? m1_byteenable : m0_byteenable;
        s_burstcount = sel ? m1_burstcount : m0_burstcount;
        s_read       = rst_n && (state_q == IDLE) && (sel ? m1_read : m0_read);
        s_write      = rst_n && (state_q != READ) && (sel ? m1_write : m0_write);

        m0_waitrequest = !rst_n || (state_q == READ) || sel  || s_waitrequest;
        m1_waitrequest = !rst_n || (state_q == READ) || !sel || s_waitrequest;

        fwd              = rst_n && (state_q == READ) && s_readdatavalid;
        m0_readdatavalid = fwd && !owner_q;
        m1_readdatavalid = fwd && owner_q;
        m0_readdata      = s_readdata;
        m1_readdata      = s_readdata;
    end

    always_comb begin
        state_d = state_q;
        beats_d = beats_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (s_read && !s_waitrequest) begin
                    owner_d = gnt;
                    beats_d = (s_burstcount == 4'd0) ? 4'd1 : s_burstcount;
                    state_d = READ;
                end else if (s_write && !s_waitrequest) begin
                    if (s_burstcount <= 4'd1) begin
                        last_d = gnt;
                    end else begin
                        owner_d = gnt;
                        beats_d = s_burstcount - 4'd1;
                        state_d = WRITE;
                    end
                end
            end
            READ: begin
                if (s_readdatavalid) begin
                    beats_d = beats_q - 4'd1;
                    if (beats_q == 4'd1) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                    end
                end
            end
            WRITE: begin
                // An owner that pauses mid-burst keeps the lock indefinitely.
                if (s_write && !s_waitrequest) begin
                    beats_d = beats_q - 4'd1;
                    if (beats_q == 4'd1) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beats_q <= 4'd0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            beats_q <= beats_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_avm_arbiter2.sv
// Scoreboard bench for avm_arbiter2: expected write beats and read returns are
// queued as stimulus is driven and checked when the slave side shows them.
module tb_avm_arbiter2;

    logic        clk, rst_n;
    logic [29:0] m0_address, m1_address;
    logic [31:0] m0_writedata, m1_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable, m0_burstcount, m1_burstcount;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic        m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic [29:0] s_address;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable, s_burstcount;
    logic        s_read, s_write;
    logic        s_waitrequest, s_readdatavalid;
    logic [31:0] s_readdata;

    logic        fp_m0_waitrequest, fp_m0_readdatavalid, fp_m1_waitrequest, fp_m1_readdatavalid;
    logic [31:0] fp_m0_readdata, fp_m1_readdata;
    logic [29:0] fp_s_address;
    logic [31:0] fp_s_writedata;
    logic [3:0]  fp_s_byteenable, fp_s_burstcount;
    logic        fp_s_read, fp_s_write;

    avm_arbiter2 #(.RR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_address(m0_address), .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_burstcount(m0_burstcount), .m0_read(m0_read), .m0_write(m0_write),
        .m0_waitrequest(m0_waitrequest), .m0_readdatavalid(m0_readdatavalid), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_burstcount(m1_burstcount), .m1_read(m1_read), .m1_write(m1_write),
        .m1_waitrequest(m1_waitrequest), .m1_readdatavalid(m1_readdatavalid), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_burstcount(s_burstcount), .s_read(s_read), .s_write(s_write),
        .s_waitrequest(s_waitrequest), .s_readdatavalid(s_readdatavalid), .s_readdata(s_readdata)
    );

    avm_arbiter2 #(.RR(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_address(m0_address), .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_burstcount(m0_burstcount), .m0_read(m0_read), .m0_write(m0_write),
        .m0_waitrequest(fp_m0_waitrequest), .m0_readdatavalid(fp_m0_readdatavalid), .m0_readdata(fp_m0_readdata),
        .m1_address(m1_address), .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_burstcount(m1_burstcount), .m1_read(m1_read), .m1_write(m1_write),
        .m1_waitrequest(fp_m1_waitrequest), .m1_readdatavalid(fp_m1_readdatavalid), .m1_readdata(fp_m1_readdata),
        .s_address(fp_s_address), .s_writedata(fp_s_writedata), .s_byteenable(fp_s_byteenable),
        .s_burstcount(fp_s_burstcount), .s_read(fp_s_read), .s_write(fp_s_write),
        .s_waitrequest(s_waitrequest), .s_readdatavalid(s_readdatavalid), .s_readdata(s_readdata)
    );

    typedef struct packed { logic [29:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic mst; logic [31:0] data; } rd_t;

    wr_t wr_q[$];
    rd_t rd_q[$];
    int  n_chk  = 0;
    int  n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        else             n_pass++;
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Slave-side monitor: pops the scoreboard on every forwarded read beat
    // and every accepted write beat.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m0_readdatavalid || m1_readdatavalid) begin
                if (rd_q.size() == 0) begin
                    check_eq("rd_unexpected", 64'(1), 64'(0));
                end else begin
                    rd_t e;
                    e = rd_q.pop_front();
                    check_eq("rd_both", 64'(m0_readdatavalid & m1_readdatavalid), 64'(0));
                    check_eq("rd_mst", 64'(m1_readdatavalid), 64'(e.mst));
                    check_eq("rd_data0", 64'(m0_readdata), 64'(e.data));
                    check_eq("rd_data1", 64'(m1_readdata), 64'(e.data));
                end
            end
            if (s_write && !s_waitrequest) begin
                if (wr_q.size() == 0) begin
                    check_eq("wr_unexpected", 64'(1), 64'(0));
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check_eq("wr_addr", 64'(s_address), 64'(w.addr));
                    check_eq("wr_data", 64'(s_writedata), 64'(w.data));
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        m0_address = '0; m0_writedata = '0; m0_byteenable = 4'hF; m0_burstcount = 4'd1;
        m1_address = '0; m1_writedata = '0; m1_byteenable = 4'hF; m1_burstcount = 4'd1;
        m0_read = 1'b0; m0_write = 1'b1; m1_read = 1'b1; m1_write = 1'b0;
        s_waitrequest = 1'b0; s_readdatavalid = 1'b1; s_readdata = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_s_read", 64'(s_read), 64'(0));
        check_eq("rst_s_write", 64'(s_write), 64'(0));
        check_eq("rst_m0_wait", 64'(m0_waitrequest), 64'(1));
        check_eq("rst_m1_wait", 64'(m1_waitrequest), 64'(1));
        check_eq("rst_m0_rdv", 64'(m0_readdatavalid), 64'(0));
        check_eq("rst_m1_rdv", 64'(m1_readdatavalid), 64'(0));
        check_eq("rst_fp_rdv", 64'({fp_m0_readdatavalid, fp_m1_readdatavalid}), 64'(0));
        check_eq("rst_fp_rdata", 64'({fp_m0_readdata, fp_m1_readdata}), 64'({32'h1234_5678, 32'h1234_5678}));
        m0_write = 1'b0; m1_read = 1'b0; s_readdatavalid = 1'b0;
        rst_n = 1'b1;
        next_cycle();

        // Both masters issue single writes every cycle.
        m0_write = 1'b1; m0_address = 30'h10; m0_writedata = 32'hD0D0_0000;
        m1_write = 1'b1; m1_address = 30'h20; m1_writedata = 32'hD1D1_0000;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 1) wr_q.push_back('{addr: 30'h20, data: 32'hD1D1_0000});
            else            wr_q.push_back('{addr: 30'h10, data: 32'hD0D0_0000});
            @(negedge clk);
            check_eq("rr_m0_wait", 64'(m0_waitrequest), 64'(i % 2));
            check_eq("rr_m1_wait", 64'(m1_waitrequest), 64'(1 - i % 2));
            check_eq("fp_s_addr", 64'(fp_s_address), 64'h10);
            check_eq("fp_s_wdata", 64'(fp_s_writedata), 64'hD0D0_0000);
            check_eq("fp_s_cmd", 64'({fp_s_read, fp_s_write, fp_s_burstcount, fp_s_byteenable}), 64'({1'b0, 1'b1, 4'd1, 4'hF}));
            check_eq("fp_wait", 64'({fp_m0_waitrequest, fp_m1_waitrequest}), 64'({1'b0, 1'b1}));
            next_cycle();
        end
        m0_write = 1'b0; m1_write = 1'b0;

        // m0 read burst of 2; m1 write arrives while it is outstanding.
        m0_read = 1'b1; m0_address = 30'h100; m0_burstcount = 4'd2; m0_byteenable = 4'h3;
        @(negedge clk);
        check_eq("rd2_s_bc", 64'(s_burstcount), 64'd2);
        check_eq("rd2_s_addr", 64'(s_address), 64'h100);
        check_eq("rd2_s_be", 64'(s_byteenable), 64'h3);
        check_eq("rd2_s_read", 64'(s_read), 64'(1));
        check_eq("rd2_wait", 64'({m0_waitrequest, m1_waitrequest}), 64'({1'b0, 1'b1}));
        next_cycle();
        m0_read = 1'b0; m0_burstcount = 4'd1; m0_byteenable = 4'hF;
        m1_write = 1'b1; m1_address = 30'h30; m1_writedata = 32'hE1E1_E1E1;
        s_readdatavalid = 1'b1; s_readdata = 32'hA0A0_A0A0;
        rd_q.push_back('{mst: 1'b0, data: 32'hA0A0_A0A0});
        @(negedge clk);
        check_eq("rd2_b1_wait", 64'({m0_waitrequest, m1_waitrequest}), 64'({1'b1, 1'b1}));
        check_eq("rd2_b1_cmd", 64'({s_read, s_write}), 64'(0));
        next_cycle();
        s_readdatavalid = 1'b0;
        @(negedge clk);
        check_eq("rd2_gap_m1_wait", 64'(m1_waitrequest), 64'(1));
        next_cycle();
        s_readdatavalid = 1'b1; s_readdata = 32'hA1A1_A1A1;
        rd_q.push_back('{mst: 1'b0, data: 32'hA1A1_A1A1});
        @(negedge clk);
        check_eq("rd2_last_m1_wait", 64'(m1_waitrequest), 64'(1));
        next_cycle();
        s_readdatavalid = 1'b0;
        wr_q.push_back('{addr: 30'h30, data: 32'hE1E1_E1E1});
        @(negedge clk);
        check_eq("idle_m1_wait", 64'(m1_waitrequest), 64'(0));
        check_eq("idle_s_write", 64'(s_write), 64'(1));
        next_cycle();
        m1_write = 1'b0;

        // m1 write burst of 3 stalled on beat 2 while m0 wants a read.
        m1_write = 1'b1; m1_address = 30'h40; m1_burstcount = 4'd3; m1_writedata = 32'hB0;
        wr_q.push_back('{addr: 30'h40, data: 32'hB0});
        @(negedge clk);
        check_eq("wb_b0_m1_wait", 64'(m1_waitrequest), 64'(0));
        next_cycle();
        m1_writedata = 32'hB1; s_waitrequest = 1'b1;
        m0_read = 1'b1; m0_address = 30'h200; m0_burstcount = 4'd1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("wb_stall_wait", 64'({m0_waitrequest, m1_waitrequest}), 64'({1'b1, 1'b1}));
            check_eq("wb_stall_addr", 64'(s_address), 64'h40);
            check_eq("wb_stall_read", 64'(s_read), 64'(0));
            next_cycle();
        end
        s_waitrequest = 1'b0;
        wr_q.push_back('{addr: 30'h40, data: 32'hB1});
        @(negedge clk);
        check_eq("wb_b1_wait", 64'({m0_waitrequest, m1_waitrequest}), 64'({1'b1, 1'b0}));
        next_cycle();
        m1_writedata = 32'hB2;
        wr_q.push_back('{addr: 30'h40, data: 32'hB2});
        @(negedge clk);
        check_eq("wb_b2_m0_wait", 64'(m0_waitrequest), 64'(1));
        next_cycle();
        m1_write = 1'b0; m1_burstcount = 4'd1;
        @(negedge clk);
        check_eq("wb_after_m0_wait", 64'(m0_waitrequest), 64'(0));
        check_eq("wb_after_read", 64'(s_read), 64'(1));
        check_eq("wb_after_addr", 64'(s_address), 64'h200);
        next_cycle();
        m0_read = 1'b0;

        // Reset while the 1-beat read is outstanding.
        m1_write = 1'b1; m1_address = 30'h50; m1_writedata = 32'hF1F1_F1F1;
        s_readdatavalid = 1'b1; s_readdata = 32'h0BAD_0BAD;
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_rdv", 64'({m0_readdatavalid, m1_readdatavalid}), 64'(0));
        check_eq("arst_wait", 64'({m0_waitrequest, m1_waitrequest}), 64'({1'b1, 1'b1}));
        check_eq("arst_cmd", 64'({s_read, s_write}), 64'(0));
        #1 rst_n = 1'b1;
        wr_q.push_back('{addr: 30'h50, data: 32'hF1F1_F1F1});
        @(negedge clk);
        check_eq("arst_late_rdv", 64'({m0_readdatavalid, m1_readdatavalid}), 64'(0));
        check_eq("arst_m1_wait", 64'(m1_waitrequest), 64'(0));
        check_eq("arst_s_write", 64'(s_write), 64'(1));
        next_cycle();
        m1_write = 1'b0; s_readdatavalid = 1'b0;

        // Burstcount 0 read is a single beat.
        m0_read = 1'b1; m0_address = 30'h300; m0_burstcount = 4'd0;
        @(negedge clk);
        check_eq("bc0_read", 64'({s_read, m0_waitrequest}), 64'({1'b1, 1'b0}));
        next_cycle();
        m0_read = 1'b0; m0_burstcount = 4'd1;
        s_readdatavalid = 1'b1; s_readdata = 32'hC0C0_C0C0;
        rd_q.push_back('{mst: 1'b0, data: 32'hC0C0_C0C0});
        next_cycle();
        s_readdata = 32'h5A5A_5A5A;
        @(negedge clk);
        check_eq("spur_rdv", 64'({m0_readdatavalid, m1_readdatavalid}), 64'(0));
        next_cycle();
        s_readdatavalid = 1'b0;
        m1_read = 1'b1; m1_address = 30'h400;
        @(negedge clk);
        check_eq("m1rd_wait", 64'(m1_waitrequest), 64'(0));
        check_eq("m1rd_read", 64'(s_read), 64'(1));
        check_eq("m1rd_addr", 64'(s_address), 64'h400);
        next_cycle();
        m1_read = 1'b0;
        s_readdatavalid = 1'b1; s_readdata = 32'hC1C1_C1C1;
        rd_q.push_back('{mst: 1'b1, data: 32'hC1C1_C1C1});
        next_cycle();
        s_readdatavalid = 1'b0;
        next_cycle();

        check_eq("rd_q_drained", 64'(rd_q.size()), 64'(0));
        check_eq("wr_q_drained", 64'(wr_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
